// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared state, operation types and op decode for the shifters
package shifter_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef enum logic [2:0] {SHL, SHRL, SHRA, ROTL, ROTR} shop_t;

    // Rotate wins over shift; the arithmetic flag only matters for right shifts.
    function automatic shop_t decode_op(input logic ar, input logic lr, input logic rot);
        if (rot) begin
            return lr ? ROTL : ROTR;
        end
        if (lr) begin
            return SHL;
        end
        return ar ? SHRA : SHRL;
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - single bit-position shift/rotate step
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  shop_t            op,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            SHL:     q = {d[WIDTH-2:0], 1'b0};
            SHRL:    q = {1'b0, d[WIDTH-1:1]};
            SHRA:    q = {d[WIDTH-1], d[WIDTH-1:1]};
            ROTL:    q = {d[WIDTH-2:0], d[WIDTH-1]};
            ROTR:    q = {d[0], d[WIDTH-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multicycle shifter, one bit position per clock, valid/ready in and out
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [NW-1:0]    in_n,
    input  logic             in_ar,
    input  logic             in_lr,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [NW-1:0] W_N = NW'(WIDTH);

    state_t           state_q, state_d;
    shop_t            op_q;
    shop_t            accept_op;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_q;
    logic [NW-1:0]    count_q;
    logic [NW-1:0]    accept_count;

    assign accept_op = decode_op(in_ar, in_lr, in_rot);

    // Rotates wrap the amount; shifts saturate at WIDTH, which already empties or sign-fills the word.
    always_comb begin
        accept_count = in_n;
        if (in_rot) begin
            accept_count = in_n % W_N;
        end else if (in_n > W_N) begin
            accept_count = W_N;
        end
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d  (data_q),
        .op (op_q),
        .q  (step_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (accept_count == '0) ? DONE : SHIFT;
            SHIFT:   if (count_q == NW'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
            op_q    <= SHRL;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                data_q  <= in_data;
                count_q <= accept_count;
                op_q    <= accept_op;
            end else if (state_q == SHIFT) begin
                data_q  <= step_q;
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

endmodule
